// File: rtl/proc_stim_ctrl_if.sv
// Signal bundle between the bench-side driver and proc_stim_ctrl.
// The slave modport is the controller's view; the master modport is the driver's view.
interface proc_stim_ctrl_if #(
  parameter int W    = 16,
  parameter int PC_W = 32
);
  logic            proc_rst;
  logic [31:0]     cyc_cnt;
  logic            in_push;
  logic [W-1:0]    in_data;
  logic            in_full;
  logic            in_empty;
  logic            in_adv;
  logic [W-1:0]    in_port;
  logic            int_req;
  logic [31:0]     int_at;
  logic            int_busy;
  logic            interrupt;
  logic [PC_W-1:0] pc;
  logic [W-1:0]    out_port;
  logic            out_chg;
  logic [W-1:0]    out_last;
  logic [15:0]     out_cnt;
  logic            hang;

  modport slave (
    input  in_push, in_data, in_adv, int_req, int_at, pc, out_port,
    output proc_rst, cyc_cnt, in_full, in_empty, in_port, int_busy, interrupt,
           out_chg, out_last, out_cnt, hang
  );

  modport master (
    output in_push, in_data, in_adv, int_req, int_at, pc, out_port,
    input  proc_rst, cyc_cnt, in_full, in_empty, in_port, int_busy, interrupt,
           out_chg, out_last, out_cnt, hang
  );
endinterface

// File: rtl/proc_stim_ctrl.sv
// Stimulus/monitor engine for the pipeline processor: reset sequencing, in_port queue,
// scheduled interrupts, out_port change monitor and a PC watchdog.
module proc_stim_ctrl #(
  parameter int W           = 16,
  parameter int PC_W        = 32,
  parameter int RST_CYCLES  = 1,
  parameter int IN_DEPTH    = 8,
  parameter int INT_PULSE   = 1,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  proc_stim_ctrl_if.slave bus
);
  localparam int AW   = $clog2(IN_DEPTH);
  localparam int HC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int PL_W = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
  localparam int WD_W = $clog2(WDOG_CYCLES);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_HANG} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state_q, state_d;
  logic [HC_W-1:0] hold_q;
  logic [31:0]     cyc_q;
  logic [WD_W-1:0] wdog_q, wdog_inc;
  logic [PC_W-1:0] pc_prev_q;
  logic [W-1:0]    mem [IN_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic [W-1:0]    in_port_q;
  logic            armed_q, irq_q;
  logic [31:0]     target_q;
  logic [PL_W-1:0] pulse_q;
  logic            mon_init_q, out_chg_q;
  logic [W-1:0]    out_last_q;
  logic [15:0]     out_cnt_q;

  logic hold_done, pc_same, wdog_hit, full, empty, push_ok, pop_ok, busy, arm_ok;

  assign hold_done = (hold_q == HC_W'(RST_CYCLES - 1));
  assign pc_same   = (bus.pc == pc_prev_q);
  assign wdog_inc  = wdog_q + WD_W'(1);
  // Hang is declared on the edge where the unchanged-pc count reaches WDOG_CYCLES-1.
  assign wdog_hit  = (state_q == S_RUN) && pc_same && (wdog_inc == WD_W'(WDOG_CYCLES - 1));
  assign full      = (cnt_q == (AW+1)'(IN_DEPTH));
  assign empty     = (cnt_q == '0);
  assign pop_ok    = bus.in_adv && !empty;
  assign push_ok   = bus.in_push && (!full || bus.in_adv);
  assign busy      = armed_q || irq_q;
  assign arm_ok    = (state_q == S_RUN) && !busy && bus.int_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:  if (hold_done) state_d = S_RUN;
      S_RUN:   if (wdog_hit) state_d = S_HANG;
      S_HANG:  state_d = S_HANG;
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HOLD;
      hold_q     <= '0;
      cyc_q      <= '0;
      wdog_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      in_port_q  <= '0;
      armed_q    <= 1'b0;
      irq_q      <= 1'b0;
      pulse_q    <= '0;
      mon_init_q <= 1'b0;
      out_chg_q  <= 1'b0;
      out_last_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_HOLD && !hold_done) hold_q <= hold_q + HC_W'(1);
      if (state_q == S_RUN) cyc_q <= cyc_q + 32'd1;
      wdog_q <= (state_q == S_RUN && pc_same) ? wdog_inc : '0;

      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok) begin
        rd_q      <= rd_q + AW'(1);
        in_port_q <= mem[rd_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase

      // Interrupt scheduling only runs in RUN; HOLD and HANG keep it idle and disarmed.
      if (state_q == S_RUN) begin
        if (irq_q) begin
          if (pulse_q == '0) irq_q <= 1'b0;
          else               pulse_q <= pulse_q - PL_W'(1);
        end else if (armed_q && cyc_q >= target_q) begin
          irq_q   <= 1'b1;
          armed_q <= 1'b0;
          pulse_q <= PL_W'(INT_PULSE - 1);
        end else if (arm_ok) begin
          armed_q <= 1'b1;
        end
      end else begin
        armed_q <= 1'b0;
        irq_q   <= 1'b0;
        pulse_q <= '0;
      end

      // The first post-HOLD sample only seeds out_last.
      if (state_q != S_HOLD) begin
        if (!mon_init_q) begin
          mon_init_q <= 1'b1;
          out_last_q <= bus.out_port;
          out_chg_q  <= 1'b0;
        end else if (bus.out_port != out_last_q) begin
          out_last_q <= bus.out_port;
          out_chg_q  <= 1'b1;
          out_cnt_q  <= sat_inc16(out_cnt_q);
        end else begin
          out_chg_q  <= 1'b0;
        end
      end else begin
        out_chg_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= bus.in_data;
    if (arm_ok)  target_q  <= bus.int_at;
    pc_prev_q <= bus.pc;
  end

  assign bus.proc_rst  = (state_q == S_HOLD);
  assign bus.hang      = (state_q == S_HANG);
  assign bus.cyc_cnt   = cyc_q;
  assign bus.in_full   = full;
  assign bus.in_empty  = empty;
  assign bus.in_port   = in_port_q;
  assign bus.int_busy  = busy;
  assign bus.interrupt = irq_q;
  assign bus.out_chg   = out_chg_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cnt   = out_cnt_q;
endmodule

// File: tb/tb_proc_stim_ctrl.sv
// Directed bench for proc_stim_ctrl: reset sequencing, interrupt scheduling, queue,
// out_port monitor and watchdog hang, each against hand-computed values.
module tb_proc_stim_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;
  int unsigned cyc_exp;
  int unsigned hang_cyc;
  bit   counting;
  bit   pc_free;

  proc_stim_ctrl_if #(.W(16), .PC_W(32)) bus ();

  proc_stim_ctrl #(
    .W(16), .PC_W(32), .RST_CYCLES(2), .IN_DEPTH(8), .INT_PULSE(2), .WDOG_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (counting) cyc_exp++;
    if (pc_free) bus.pc = bus.pc + 32'd4;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    cyc_exp = 0; counting = 1'b0; pc_free = 1'b1;
    rst = 1'b1;
    bus.in_push = 1'b0; bus.in_data = '0; bus.in_adv = 1'b0;
    bus.int_req = 1'b0; bus.int_at = '0;
    bus.pc = 32'h1000; bus.out_port = '0;

    repeat (3) step();
    chk("rst_proc_rst", bus.proc_rst, 1);
    chk("rst_cyc_cnt", bus.cyc_cnt, 0);
    chk("rst_in_empty", bus.in_empty, 1);
    chk("rst_in_full", bus.in_full, 0);
    chk("rst_interrupt", bus.interrupt, 0);
    chk("rst_int_busy", bus.int_busy, 0);
    chk("rst_hang", bus.hang, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    chk("rst_in_port", bus.in_port, 0);

    rst = 1'b0;
    step();
    chk("hold_edge1", bus.proc_rst, 1);
    step();
    chk("hold_release", bus.proc_rst, 0);
    chk("run_cyc0", bus.cyc_cnt, 0);
    counting = 1'b1;
    step();
    chk("run_cyc1", bus.cyc_cnt, 1);
    step();
    chk("run_cyc2", bus.cyc_cnt, 2);

    // Interrupt at 10 requested at cycle 4; request at cycle 6 must be ignored.
    step(); step();
    chk("cyc4", bus.cyc_cnt, 4);
    bus.int_req = 1'b1; bus.int_at = 32'd10;
    step();
    chk("int_armed_busy", bus.int_busy, 1);
    chk("int_armed_idle", bus.interrupt, 0);
    bus.int_req = 1'b0;
    step();
    bus.int_req = 1'b1; bus.int_at = 32'd7;
    step();
    bus.int_req = 1'b0;
    chk("int_busy_c7", bus.int_busy, 1);
    step();
    chk("int_ignored_c8", bus.interrupt, 0);
    step(); step();
    chk("int_c10", bus.interrupt, 0);
    step();
    chk("int_c11", bus.interrupt, 1);
    step();
    chk("int_c12", bus.interrupt, 1);
    step();
    chk("int_c13", bus.interrupt, 0);
    chk("int_busy_c13", bus.int_busy, 0);

    while (cyc_exp < 20) step();
    bus.int_req = 1'b1; bus.int_at = 32'd3;
    step();
    bus.int_req = 1'b0;
    chk("int_past_c21", bus.interrupt, 0);
    chk("int_past_busy", bus.int_busy, 1);
    step();
    chk("int_past_c22", bus.interrupt, 1);
    step();
    chk("int_past_c23", bus.interrupt, 1);
    step();
    chk("int_past_c24", bus.interrupt, 0);
    chk("cyc_c24", bus.cyc_cnt, cyc_exp);

    // Queue: basic order, empty-advance hold.
    bus.in_push = 1'b1; bus.in_data = 16'h0005;
    step();
    bus.in_data = 16'h0007;
    step();
    bus.in_push = 1'b0;
    chk("q_not_empty", bus.in_empty, 0);
    bus.in_adv = 1'b1;
    step();
    chk("q_pop1", bus.in_port, 16'h0005);
    step();
    chk("q_pop2", bus.in_port, 16'h0007);
    step();
    chk("q_pop_empty", bus.in_port, 16'h0007);
    bus.in_adv = 1'b0;
    chk("q_empty", bus.in_empty, 1);

    // Queue: fill, drop 9th push, push+adv while full.
    bus.in_push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 16'h0010 + 16'(i);
      step();
    end
    chk("q_full", bus.in_full, 1);
    bus.in_data = 16'h0099;
    step();
    chk("q_full_drop", bus.in_full, 1);
    bus.in_data = 16'h0020; bus.in_adv = 1'b1;
    step();
    bus.in_push = 1'b0;
    chk("q_pushpop_port", bus.in_port, 16'h0010);
    chk("q_pushpop_full", bus.in_full, 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("q_drain", bus.in_port, 32'h0010 + 32'(i));
    end
    step();
    chk("q_drain_last", bus.in_port, 16'h0020);
    bus.in_adv = 1'b0;
    chk("q_drained_empty", bus.in_empty, 1);

    // Monitor: 0 -> 00FF -> 00FF -> 1234.
    chk("mon_cnt0", bus.out_cnt, 0);
    chk("mon_chg0", bus.out_chg, 0);
    bus.out_port = 16'h00FF;
    step();
    chk("mon_chg1", bus.out_chg, 1);
    chk("mon_last1", bus.out_last, 16'h00FF);
    chk("mon_cnt1", bus.out_cnt, 1);
    step();
    chk("mon_same", bus.out_chg, 0);
    chk("mon_cnt_same", bus.out_cnt, 1);
    bus.out_port = 16'h1234;
    step();
    chk("mon_chg2", bus.out_chg, 1);
    chk("mon_cnt2", bus.out_cnt, 2);
    chk("mon_last2", bus.out_last, 16'h1234);
    step();
    chk("mon_chg_off", bus.out_chg, 0);

    // Watchdog: arm a far interrupt, then freeze pc.
    bus.int_req = 1'b1; bus.int_at = cyc_exp + 32'd1000;
    step();
    bus.int_req = 1'b0;
    chk("wd_armed", bus.int_busy, 1);
    pc_free = 1'b0;
    bus.pc = 32'h20;
    repeat (15) step();
    chk("wd_not_yet", bus.hang, 0);
    step();
    chk("wd_hang", bus.hang, 1);
    chk("wd_cyc_at_hang", bus.cyc_cnt, cyc_exp);
    hang_cyc = cyc_exp;
    counting = 1'b0;
    repeat (3) step();
    chk("wd_cyc_frozen", bus.cyc_cnt, hang_cyc);
    chk("wd_int_off", bus.interrupt, 0);
    chk("wd_int_dropped", bus.int_busy, 0);
    chk("wd_sticky", bus.hang, 1);

    // Queue and monitor still run in HANG.
    bus.in_push = 1'b1; bus.in_data = 16'h0ABC;
    step();
    bus.in_push = 1'b0; bus.in_adv = 1'b1;
    step();
    bus.in_adv = 1'b0;
    chk("hang_q", bus.in_port, 16'h0ABC);
    bus.out_port = 16'h5555;
    step();
    chk("hang_mon_chg", bus.out_chg, 1);
    chk("hang_mon_cnt", bus.out_cnt, 3);

    rst = 1'b1;
    #1;
    chk("rst2_hang", bus.hang, 0);
    chk("rst2_proc_rst", bus.proc_rst, 1);
    chk("rst2_cyc", bus.cyc_cnt, 0);
    chk("rst2_out_cnt", bus.out_cnt, 0);
    chk("rst2_out_last", bus.out_last, 0);
    chk("rst2_in_empty", bus.in_empty, 1);
    chk("rst2_in_port", bus.in_port, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
